// File: rtl/i2c_txn_sequencer_pkg.sv
// Shared types for the i2c transaction sequencer: FSM states, latched request
// fields and the address-byte helper.
package i2c_txn_sequencer_pkg;

  localparam int I2C_WIDTH = 8;
  localparam int RNW_BIT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_W = 3'd1,
    ST_REG    = 3'd2,
    ST_WDATA  = 3'd3,
    ST_ADDR_R = 3'd4,
    ST_RSLOT  = 3'd5,
    ST_DRAIN  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  typedef struct packed {
    logic                 rnw;
    logic [6:0]           dev;
    logic [I2C_WIDTH-1:0] regb;
  } req_t;

  function automatic logic [I2C_WIDTH-1:0] addr_byte(input logic [6:0] dev, input logic rnw);
    logic [I2C_WIDTH-1:0] b;
    b          = {dev, 1'b0};
    b[RNW_BIT] = rnw;
    return b;
  endfunction

endpackage

// File: rtl/i2c_txn_sequencer_rx_timeout.sv
// Loadable down-counter; expired_o flags a full RX_TIMEOUT window with no reload.
module i2c_txn_sequencer_rx_timeout #(
  parameter int unsigned CYC = 65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expired_o
);

  localparam int CW = $clog2(CYC + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = RELOAD;
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

  // A pop in the same cycle wins over expiry.
  assign expired_o = (cnt_q == '0) && !load_i;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Converts register-level read/write requests into i2c core tx packets and
// drains the core rx FIFO back to the requester. One transaction in flight.
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int LEN_W          = 5,
  parameter int RX_TIMEOUT_CYC = 65536
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_rnw_i,
  input  logic [6:0]           req_dev_i,
  input  logic [7:0]           req_reg_i,
  input  logic [LEN_W-1:0]     req_len_i,
  input  logic                 wdata_valid_i,
  input  logic [7:0]           wdata_i,
  output logic                 wdata_ready_o,
  output logic                 rdata_valid_o,
  output logic [7:0]           rdata_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 i2c_wr_stb_o,
  output logic                 i2c_restart_o,
  output logic                 i2c_stop_o,
  output logic                 i2c_cdm_o,
  output logic [7:0]           i2c_din_o,
  input  logic                 i2c_tx_full_i,
  output logic                 i2c_rd_stb_o,
  input  logic [7:0]           i2c_dout_i,
  input  logic                 i2c_rx_empty_i
);

  localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_LEN);

  state_e           state_q;
  req_t             req_q;
  logic [LEN_W-1:0] len_q, cnt_q, rcvd_q;
  logic [7:0]       rdata_q;
  logic             rdata_vld_q, done_q, err_q;

  logic             pkt_vld, last, push, drain_act, rd_stb, tmo_load, tmo_exp, bad_req;

  // Packet fields decode from state so they stay put while the tx FIFO is full.
  always_comb begin
    pkt_vld       = 1'b0;
    i2c_restart_o = 1'b0;
    i2c_stop_o    = 1'b0;
    i2c_cdm_o     = 1'b0;
    i2c_din_o     = '0;
    last          = (cnt_q == len_q - LEN_W'(1));
    case (state_q)
      ST_ADDR_W: begin
        pkt_vld       = 1'b1;
        i2c_restart_o = 1'b1;
        i2c_din_o     = addr_byte(req_q.dev, 1'b0);
      end
      ST_REG: begin
        pkt_vld    = 1'b1;
        i2c_din_o  = req_q.regb;
        i2c_stop_o = !req_q.rnw && (len_q == '0);
      end
      ST_WDATA: begin
        pkt_vld    = wdata_valid_i;
        i2c_din_o  = wdata_i;
        i2c_stop_o = last;
      end
      ST_ADDR_R: begin
        pkt_vld       = 1'b1;
        i2c_restart_o = 1'b1;
        i2c_din_o     = addr_byte(req_q.dev, 1'b1);
      end
      ST_RSLOT: begin
        pkt_vld    = !tmo_exp;
        i2c_cdm_o  = 1'b1;
        i2c_din_o  = {7'b0, last};
        i2c_stop_o = last;
      end
      default: ;
    endcase
  end

  assign push          = pkt_vld && !i2c_tx_full_i;
  assign i2c_wr_stb_o  = push;
  assign wdata_ready_o = (state_q == ST_WDATA) && wdata_valid_i && !i2c_tx_full_i;

  // Draining starts once the first read slot is in the core.
  assign drain_act    = ((state_q == ST_RSLOT) && (cnt_q != '0)) || (state_q == ST_DRAIN);
  assign rd_stb       = drain_act && !i2c_rx_empty_i && (rcvd_q != len_q);
  assign i2c_rd_stb_o = rd_stb;
  assign tmo_load     = !drain_act || rd_stb;

  assign bad_req = (req_rnw_i && (req_len_i == '0)) || ({1'b0, req_len_i} > MAX_L);

  i2c_txn_sequencer_rx_timeout #(.CYC(RX_TIMEOUT_CYC)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmo_load),
    .expired_o (tmo_exp)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rcvd_q      <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rdata_vld_q <= rd_stb;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      if (rd_stb) begin
        rdata_q <= i2c_dout_i;
        rcvd_q  <= rcvd_q + LEN_W'(1);
      end
      case (state_q)
        ST_IDLE: if (req_valid_i) begin
          req_q  <= '{rnw: req_rnw_i, dev: req_dev_i, regb: req_reg_i};
          len_q  <= req_len_i;
          cnt_q  <= '0;
          rcvd_q <= '0;
          if (bad_req) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_ADDR_W;
          end
        end
        ST_ADDR_W: if (push) state_q <= ST_REG;
        ST_REG: if (push) begin
          if (req_q.rnw)          state_q <= ST_ADDR_R;
          else if (len_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else                state_q <= ST_WDATA;
        end
        ST_WDATA: if (push) begin
          cnt_q <= cnt_q + LEN_W'(1);
          if (last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_ADDR_R: if (push) state_q <= ST_RSLOT;
        ST_RSLOT: begin
          if (tmo_exp) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (push) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Finish once the last byte has been presented on rdata.
          if ((rcvd_q == len_q) && rdata_vld_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (tmo_exp) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_vld_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with packet/rdata scoreboards and a small rx FIFO model.
module tb_i2c_txn_sequencer;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int TMO     = 200;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 0, req_rnw = 0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic wdata_valid = 0; logic [7:0] wdata = '0;
  logic tx_full = 0, rx_empty = 1; logic [7:0] dout = '0;
  logic req_ready, wdata_ready, rdata_valid, done, err;
  logic wr_stb, restart, stop, cdm, rd_stb;
  logic [7:0] rdata, din;

  i2c_txn_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RX_TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rnw_i(req_rnw), .req_dev_i(req_dev), .req_reg_i(req_reg), .req_len_i(req_len),
    .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
    .rdata_valid_o(rdata_valid), .rdata_o(rdata), .done_o(done), .err_o(err),
    .i2c_wr_stb_o(wr_stb), .i2c_restart_o(restart), .i2c_stop_o(stop), .i2c_cdm_o(cdm),
    .i2c_din_o(din), .i2c_tx_full_i(tx_full), .i2c_rd_stb_o(rd_stb),
    .i2c_dout_i(dout), .i2c_rx_empty_i(rx_empty)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int cyc = 0, push_cnt = 0, last_push_cyc = 0, last_rv_cyc = 0, acc_cyc = 0, done_cyc = 0;
  logic [10:0] exp_pkt[$];
  logic [7:0]  exp_rd[$], wd_q[$], supply[$], rx_fifo[$];
  bit pop_pend = 0, wd_adv = 0, rx_push_pend = 0;
  logic [7:0] rx_push_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] pk(input logic r, input logic s, input logic c, input logic [7:0] d);
    return {r, s, c, d};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard compares plus intents for the rx/wdata driver.
  always @(negedge clk) begin
    pop_pend     = rd_stb;
    wd_adv       = wdata_ready;
    rx_push_pend = 1'b0;
    if (wr_stb) begin
      push_cnt++;
      last_push_cyc = cyc;
      if (exp_pkt.size() == 0) chk("pkt_unexpected", {21'b0, restart, stop, cdm, din}, 32'hFFFF);
      else chk("pkt", {21'b0, restart, stop, cdm, din}, {21'b0, exp_pkt.pop_front()});
      if (cdm && supply.size() > 0) begin
        rx_push_pend = 1'b1;
        rx_push_val  = supply.pop_front();
      end
    end
    if (rdata_valid) begin
      last_rv_cyc = cyc;
      if (exp_rd.size() == 0) chk("rdata_unexpected", {24'b0, rdata}, 32'hFFFF);
      else chk("rdata", {24'b0, rdata}, {24'b0, exp_rd.pop_front()});
    end
  end

  // Core rx FIFO (first-word fall-through) and write-data source.
  always begin
    @(posedge clk); #1;
    if (pop_pend && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
    if (rx_push_pend) rx_fifo.push_back(rx_push_val);
    rx_empty = (rx_fifo.size() == 0);
    dout     = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
    if (wd_adv && wd_q.size() > 0) void'(wd_q.pop_front());
    wdata_valid = (wd_q.size() > 0);
    wdata       = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
  end

  task automatic send_req(input logic rnw, input logic [6:0] dv, input logic [7:0] rg, input logic [LEN_W-1:0] ln);
    @(posedge clk); #1;
    req_valid = 1; req_rnw = rnw; req_dev = dv; req_reg = rg; req_len = ln;
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err, input int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      done_cyc = cyc;
      chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic chk_outs_idle(input string tag);
    chk(tag, {12'b0, wr_stb, restart, stop, cdm, din, rd_stb, rdata_valid, done, err, wdata_ready, req_ready},
        {12'b0, 16'b0, 4'b0, 1'b1});
    chk({tag, "_rdata"}, {24'b0, rdata}, 32'd0);
  endtask

  initial begin
    int p0;
    bit got;
    // Reset state
    repeat (2) @(negedge clk);
    chk_outs_idle("reset_outs");
    @(posedge clk); #1 rst = 0;

    // 1: write len 2
    wd_q = '{8'hA5, 8'h5A};
    exp_pkt = '{pk(1,0,0,8'hA0), pk(0,0,0,8'h10), pk(0,0,0,8'hA5), pk(0,1,0,8'h5A)};
    send_req(0, 7'h50, 8'h10, 2);
    wait_done("t1", 0, 50);
    chk("t1_done_lat", done_cyc, last_push_cyc + 1);
    chk("t1_pkt_left", exp_pkt.size(), 0);

    // 2: read len 3
    supply = '{8'h11, 8'h22, 8'h33};
    exp_rd = '{8'h11, 8'h22, 8'h33};
    exp_pkt = '{pk(1,0,0,8'hA0), pk(0,0,0,8'h00), pk(1,0,0,8'hA1),
                pk(0,0,1,8'h00), pk(0,0,1,8'h00), pk(0,1,1,8'h01)};
    send_req(1, 7'h50, 8'h00, 3);
    wait_done("t2", 0, 100);
    chk("t2_done_lat", done_cyc, last_rv_cyc + 1);
    chk("t2_pkt_left", exp_pkt.size(), 0);
    chk("t2_rd_left", exp_rd.size(), 0);

    // 3: write len 0
    p0 = push_cnt;
    exp_pkt = '{pk(1,0,0,8'hA0), pk(0,1,0,8'h20)};
    send_req(0, 7'h50, 8'h20, 0);
    wait_done("t3", 0, 50);
    chk("t3_pushes", push_cnt - p0, 2);
    chk("t3_done_lat", done_cyc, last_push_cyc + 1);

    // 4: tx_full stall in the middle of write data
    wd_q = '{8'hC1, 8'hC2, 8'hC3};
    exp_pkt = '{pk(1,0,0,8'h64), pk(0,0,0,8'h33), pk(0,0,0,8'hC1), pk(0,0,0,8'hC2), pk(0,1,0,8'hC3)};
    p0 = push_cnt;
    send_req(0, 7'h32, 8'h33, 3);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (push_cnt - p0 >= 2) got = 1;
    end
    chk("t4_reached_data", {31'b0, got}, 32'd1);
    @(posedge clk); #1 tx_full = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_no_stb", {30'b0, wr_stb, wdata_ready}, 32'd0);
      if (exp_pkt.size() > 0) chk("t4_held", {21'b0, restart, stop, cdm, din}, {21'b0, exp_pkt[0]});
    end
    @(posedge clk); #1 tx_full = 0;
    wait_done("t4", 0, 50);
    chk("t4_pkt_left", exp_pkt.size(), 0);
    chk("t4_pushes", push_cnt - p0, 5);

    // 5: read len 2, rx stalls after one byte -> timeout
    supply = '{8'h77};
    exp_rd = '{8'h77};
    exp_pkt = '{pk(1,0,0,8'hA0), pk(0,0,0,8'h05), pk(1,0,0,8'hA1), pk(0,0,1,8'h00), pk(0,1,1,8'h01)};
    send_req(1, 7'h50, 8'h05, 2);
    wait_done("t5", 1, TMO + 100);
    chk("t5_pkt_left", exp_pkt.size(), 0);
    chk("t5_rd_left", exp_rd.size(), 0);

    // 6: illegal lengths
    p0 = push_cnt;
    send_req(1, 7'h50, 8'h00, 0);
    wait_done("t6a", 1, 10);
    chk("t6a_lat", done_cyc, acc_cyc + 1);
    send_req(0, 7'h50, 8'h00, LEN_W'(MAX_LEN + 1));
    wait_done("t6b", 1, 10);
    chk("t6b_lat", done_cyc, acc_cyc + 1);
    send_req(1, 7'h50, 8'h00, LEN_W'(MAX_LEN + 1));
    wait_done("t6c", 1, 10);
    chk("t6_no_push", push_cnt - p0, 0);

    // Reset mid-read
    supply = '{8'h01, 8'h02, 8'h03};
    exp_pkt = '{pk(1,0,0,8'hA0), pk(0,0,0,8'h00), pk(1,0,0,8'hA1),
                pk(0,0,1,8'h00), pk(0,0,1,8'h00), pk(0,1,1,8'h01)};
    exp_rd = '{8'h01, 8'h02, 8'h03};
    send_req(1, 7'h50, 8'h00, 3);
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk_outs_idle("rst_mid_outs");
    exp_pkt.delete(); exp_rd.delete(); supply.delete(); rx_fifo.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_outs_idle("post_rst_outs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
